// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard/forwarding bundle between the pipeline control (master)
// and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int AW    = 5,
    parameter int DEPTH = 3
);
    localparam int SW = $clog2(DEPTH + 1);

    logic          hold;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic [AW-1:0] id_dst;
    logic          id_regwrite;
    logic          id_is_load;
    logic          flush;
    logic          stall;
    logic          bubble;
    logic          if_flush;
    logic [SW-1:0] fwd_sel_rs;
    logic [SW-1:0] fwd_sel_rt;
    logic [31:0]   stall_cnt;

    modport master (
        output hold, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dst, id_regwrite, id_is_load, flush,
        input  stall, bubble, if_flush, fwd_sel_rs, fwd_sel_rt, stall_cnt
    );

    modport slave (
        input  hold, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dst, id_regwrite, id_is_load, flush,
        output stall, bubble, if_flush, fwd_sel_rs, fwd_sel_rt, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight destinations (EX..WB) that decides
// ID stalls and produces EX-aligned forwarding selects.
module hazard_scoreboard #(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int BR_STAGE = 2
) (
    input  logic              clk,
    input  logic              reset,
    hazard_scoreboard_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 1);
    localparam logic [SW-1:0] RDY_ALU  = SW'(2);
    localparam logic [SW-1:0] RDY_LOAD = SW'(2 + LOAD_LAT);

    logic [DEPTH:1]           valid_q, valid_d;
    logic [DEPTH:1][AW-1:0]   dst_q, dst_d;
    logic [DEPTH:1][SW-1:0]   rdy_q, rdy_d;
    logic [SW-1:0]            fwd_sel_rs_q, fwd_sel_rs_d;
    logic [SW-1:0]            fwd_sel_rt_q, fwd_sel_rt_d;
    logic [31:0]              stall_cnt_q, stall_cnt_d;

    logic [DEPTH-1:1]         rs_m, rt_m, early;
    logic                     rs_hit, rt_hit, rs_haz, rt_haz;
    logic [SW-1:0]            rs_idx, rt_idx;
    logic                     stall, bubble;

    // sb[DEPTH] is excluded: the regfile is write-first, so WB never forwards.
    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_cmp
            assign rs_m[gi]  = valid_q[gi] && (dst_q[gi] == bus.id_rs)
                               && (bus.id_rs != '0) && bus.id_use_rs;
            assign rt_m[gi]  = valid_q[gi] && (dst_q[gi] == bus.id_rt)
                               && (bus.id_rt != '0) && bus.id_use_rt;
            assign early[gi] = (SW'(gi + 1) < rdy_q[gi]);
        end
    endgenerate

    // Scan oldest to youngest so the youngest producer ends up winning.
    always_comb begin
        rs_hit = 1'b0;
        rs_haz = 1'b0;
        rs_idx = '0;
        rt_hit = 1'b0;
        rt_haz = 1'b0;
        rt_idx = '0;
        for (int i = DEPTH - 1; i >= 1; i--) begin
            if (rs_m[i]) begin
                rs_hit = 1'b1;
                rs_haz = early[i];
                rs_idx = SW'(i + 1);
            end
            if (rt_m[i]) begin
                rt_hit = 1'b1;
                rt_haz = early[i];
                rt_idx = SW'(i + 1);
            end
        end
    end

    assign stall  = bus.id_valid && (rs_haz || rt_haz) && !bus.flush && !bus.hold;
    assign bubble = (stall || bus.flush) && !bus.hold;

    always_comb begin
        valid_d      = valid_q;
        dst_d        = dst_q;
        rdy_d        = rdy_q;
        fwd_sel_rs_d = fwd_sel_rs_q;
        fwd_sel_rt_d = fwd_sel_rt_q;
        stall_cnt_d  = stall_cnt_q;
        if (!bus.hold) begin
            // Entries younger than the resolving branch die with the flush.
            for (int i = DEPTH; i >= 2; i--) begin
                valid_d[i] = valid_q[i-1] && !(bus.flush && ((i - 1) < BR_STAGE));
                dst_d[i]   = dst_q[i-1];
                rdy_d[i]   = rdy_q[i-1];
            end
            valid_d[1]   = !bubble && bus.id_valid && bus.id_regwrite && (bus.id_dst != '0);
            dst_d[1]     = bus.id_dst;
            rdy_d[1]     = bus.id_is_load ? RDY_LOAD : RDY_ALU;
            fwd_sel_rs_d = (!bubble && bus.id_valid && rs_hit) ? rs_idx : '0;
            fwd_sel_rt_d = (!bubble && bus.id_valid && rt_hit) ? rt_idx : '0;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            dst_q        <= '0;
            rdy_q        <= '0;
            fwd_sel_rs_q <= '0;
            fwd_sel_rt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            dst_q        <= dst_d;
            rdy_q        <= rdy_d;
            fwd_sel_rs_q <= fwd_sel_rs_d;
            fwd_sel_rt_q <= fwd_sel_rt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.stall      = stall;
    assign bus.bubble     = bubble;
    assign bus.if_flush   = bus.flush && !bus.hold;
    assign bus.fwd_sel_rs = fwd_sel_rs_q;
    assign bus.fwd_sel_rt = fwd_sel_rt_q;
    assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard (defaults) plus a
// hand-written DEPTH=4 / LOAD_LAT=2 load-use sequence.
module tb_hazard_scoreboard;
    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dst;
        logic       rw;
        logic       ld;
    } ins_t;

    typedef struct packed {
        logic        rst;
        logic        hold;
        logic        flush;
        ins_t        ins;
        logic        e_stall;
        logic        e_bubble;
        logic        e_iff;
        logic [1:0]  e_frs;
        logic [1:0]  e_frt;
        logic [31:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.AW(5), .DEPTH(3)) bus0 ();
    hazard_scoreboard_if #(.AW(5), .DEPTH(4)) bus1 ();

    hazard_scoreboard #(.AW(5), .DEPTH(3), .LOAD_LAT(1), .BR_STAGE(2)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    hazard_scoreboard #(.AW(5), .DEPTH(4), .LOAD_LAT(2), .BR_STAGE(2)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    function automatic ins_t mki(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt, input logic [4:0] dst,
                                 input logic rw, input logic ld);
        ins_t r;
        r.valid = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
        r.dst = dst; r.rw = rw; r.ld = ld;
        return r;
    endfunction

    function automatic vec_t row(input logic rst, input logic hold, input logic flush,
                                 input ins_t ins, input logic es, input logic eb,
                                 input logic ei, input logic [1:0] frs,
                                 input logic [1:0] frt, input logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.hold = hold; v.flush = flush; v.ins = ins;
        v.e_stall = es; v.e_bubble = eb; v.e_iff = ei;
        v.e_frs = frs; v.e_frt = frt; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic drive0(input ins_t i, input logic hold, input logic flush);
        bus0.hold = hold; bus0.flush = flush;
        bus0.id_valid = i.valid; bus0.id_rs = i.rs; bus0.id_rt = i.rt;
        bus0.id_use_rs = i.urs; bus0.id_use_rt = i.urt; bus0.id_dst = i.dst;
        bus0.id_regwrite = i.rw; bus0.id_is_load = i.ld;
    endtask

    task automatic drive1(input ins_t i);
        bus1.hold = 1'b0; bus1.flush = 1'b0;
        bus1.id_valid = i.valid; bus1.id_rs = i.rs; bus1.id_rt = i.rt;
        bus1.id_use_rs = i.urs; bus1.id_use_rt = i.urt; bus1.id_dst = i.dst;
        bus1.id_regwrite = i.rw; bus1.id_is_load = i.ld;
    endtask

    initial begin
        ins_t idle, lw3, add3, sub4, add4_33, add0, sub4_00, sub4_53, lw7, add8_7;
        logic e4_stall [5];

        idle    = mki(0, 0, 0, 0, 0, 0, 0, 0);
        lw3     = mki(1, 1, 0, 1, 0, 3, 1, 1);
        add3    = mki(1, 1, 2, 1, 1, 3, 1, 0);
        sub4    = mki(1, 3, 5, 1, 1, 4, 1, 0);
        add4_33 = mki(1, 3, 3, 1, 1, 4, 1, 0);
        add0    = mki(1, 1, 2, 1, 1, 0, 1, 0);
        sub4_00 = mki(1, 0, 0, 1, 1, 4, 1, 0);
        sub4_53 = mki(1, 5, 3, 1, 1, 4, 1, 0);
        lw7     = mki(1, 1, 0, 1, 0, 7, 1, 1);
        add8_7  = mki(1, 7, 0, 1, 0, 8, 1, 0);

        // ALU -> ALU back-to-back
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, add3,    0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, sub4,    0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 2, 0, 0));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 0, 0, 0));
        // load-use: one stall, then forward from index 3
        tbl.push_back(row(0, 0, 0, lw3,     0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, add4_33, 1, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, add4_33, 0, 0, 0, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 3, 3, 1));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 0, 0, 1));
        // flush in the stall cycle kills the load, no forward afterwards
        tbl.push_back(row(0, 0, 0, lw3,     0, 0, 0, 0, 0, 1));
        tbl.push_back(row(0, 0, 1, add4_33, 0, 1, 1, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, add4_33, 0, 0, 0, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 0, 0, 1));
        // hold for 3 cycles mid-stall (one with flush), then a single stall
        tbl.push_back(row(0, 0, 0, lw3,     0, 0, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 0, add4_33, 0, 0, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 0, add4_33, 0, 0, 0, 0, 0, 1));
        tbl.push_back(row(0, 1, 1, add4_33, 0, 0, 0, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, add4_33, 1, 1, 0, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, add4_33, 0, 0, 0, 0, 0, 2));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 3, 3, 2));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 0, 0, 2));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 0, 0, 2));
        // r0 is never a dependency
        tbl.push_back(row(0, 0, 0, add0,    0, 0, 0, 0, 0, 2));
        tbl.push_back(row(0, 0, 0, sub4_00, 0, 0, 0, 0, 0, 2));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 0, 0, 2));
        // reset during a load-use stall
        tbl.push_back(row(0, 0, 0, lw3,     0, 0, 0, 0, 0, 2));
        tbl.push_back(row(1, 0, 0, add4_33, 1, 1, 0, 0, 0, 2));
        tbl.push_back(row(0, 0, 0, add4_33, 0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 0, 0, 0));
        // ALU producer two slots ahead forwards from index 3 on rt
        tbl.push_back(row(0, 0, 0, add3,    0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, sub4_53, 0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 0, 3, 0));
        tbl.push_back(row(0, 0, 0, idle,    0, 0, 0, 0, 0, 0));

        drive0(idle, 1'b0, 1'b0);
        drive1(idle);
        repeat (2) @(posedge clk);

        foreach (tbl[k]) begin
            @(negedge clk);
            reset = tbl[k].rst;
            drive0(tbl[k].ins, tbl[k].hold, tbl[k].flush);
            #1;
            $display("row %0d: stall=%0b bubble=%0b if_flush=%0b fwd=%0d/%0d cnt=%0d",
                     k, bus0.stall, bus0.bubble, bus0.if_flush,
                     bus0.fwd_sel_rs, bus0.fwd_sel_rt, bus0.stall_cnt);
            chk("stall",      k, 32'(bus0.stall),      32'(tbl[k].e_stall));
            chk("bubble",     k, 32'(bus0.bubble),     32'(tbl[k].e_bubble));
            chk("if_flush",   k, 32'(bus0.if_flush),   32'(tbl[k].e_iff));
            chk("fwd_sel_rs", k, 32'(bus0.fwd_sel_rs), 32'(tbl[k].e_frs));
            chk("fwd_sel_rt", k, 32'(bus0.fwd_sel_rt), 32'(tbl[k].e_frt));
            chk("stall_cnt",  k, bus0.stall_cnt,       tbl[k].e_cnt);
        end

        // DEPTH=4, LOAD_LAT=2: lw r7 then use of r7 -> two stalls, forward from 4
        e4_stall[0] = 1'b0; e4_stall[1] = 1'b1; e4_stall[2] = 1'b1;
        e4_stall[3] = 1'b0; e4_stall[4] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            reset = 1'b0;
            drive0(idle, 1'b0, 1'b0);
            if (c == 0)      drive1(lw7);
            else if (c < 4)  drive1(add8_7);
            else             drive1(idle);
            #1;
            $display("d4 cycle %0d: stall=%0b bubble=%0b fwd=%0d/%0d cnt=%0d",
                     c, bus1.stall, bus1.bubble, bus1.fwd_sel_rs, bus1.fwd_sel_rt,
                     bus1.stall_cnt);
            chk("d4_stall",  c, 32'(bus1.stall),  32'(e4_stall[c]));
            chk("d4_bubble", c, 32'(bus1.bubble), 32'(e4_stall[c]));
        end
        chk("d4_fwd_sel_rs", 4, 32'(bus1.fwd_sel_rs), 32'd4);
        chk("d4_fwd_sel_rt", 4, 32'(bus1.fwd_sel_rt), 32'd0);
        chk("d4_stall_cnt",  4, bus1.stall_cnt,       32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the pipelined MIPS core. It tracks in-flight destination registers in a shift-register scoreboard covering the EX through WB stages. Each cycle it decides whether the instruction in ID must stall, and it produces registered forwarding selects aligned to EX. It also handles branch flush, external pipeline hold, and a saturating stall counter. It generalises the fixed rs/rt forwarding and single load-use check to arbitrary pipeline depth and load latency.

## Interface
- AW, 5: register-address width.
- DEPTH, 3: scoreboard stages; index 1 = EX, index DEPTH = WB. Must be ≥ 2.
- LOAD_LAT, 1: extra stages before a load result exists. Load ready index = 2+LOAD_LAT, which must be ≤ DEPTH.
- BR_STAGE, 2: scoreboard index at which branches resolve. Range 1..DEPTH-1.
- SW = $clog2(DEPTH+1): forward-select width (derived).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- hold  in  1  external freeze (memory wait); scoreboard and outputs keep state.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  ID source registers.
- id_use_rs, id_use_rt  in  1  operand actually read.
- id_dst  in  AW  ID destination (post regdst mux).
- id_regwrite  in  1  ID writes a register.
- id_is_load  in  1  ID is a load.
- flush  in  1  taken branch/jump resolved at BR_STAGE.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- bubble  out  1  load NOP into ID/EX this edge (combinational).
- if_flush  out  1  kill IF/ID contents this edge (combinational, = flush & ~hold).
- fwd_sel_rs, fwd_sel_rt  out  SW  registered, valid while the consumer is in EX. 0 = use ID/EX regfile value; k = forward bus of scoreboard index k.
- stall_cnt  out  32  saturating count of stall cycles.

## Operation
- Entry sb[i] holds {valid, dst, rdy}; rdy = 2 for non-loads and 2+LOAD_LAT for loads. Entries are written only if id_regwrite and id_dst≠0.
- Match for operand r: the lowest i in 1..DEPTH-1 with sb[i].valid, sb[i].dst==r, r≠0 and the use flag set. The youngest match wins. sb[DEPTH] never matches because the regfile is write-first.
- Hazard: a match at i with i+1 < sb[i].rdy.
- stall = id_valid & hazard(rs or rt) & ~flush & ~hold.
- bubble = (stall | flush) & ~hold.
- Advance on every edge with hold=0: sb[i+1] ← sb[i] for all i, and sb[DEPTH] drops out.
  - sb[1] ← ID entry if ~bubble & id_valid; otherwise invalid.
  - On flush, entries sb[1..BR_STAGE-1] (younger than the branch) are invalidated before the shift, and the ID instruction is not inserted.
- fwd_sel_x ← (~bubble & id_valid & match at i) ? i+1 : 0. It is loaded on every advance.
- hold=1 freezes sb, fwd_sel and stall_cnt. stall and bubble are 0 while hold=1.
- flush overrides stall in the same cycle.
- stall_cnt increments on each cycle with stall=1 and saturates at 0xFFFFFFFF.

## Timing
- Reset (synchronous): all sb invalid, fwd_sel_rs/rt = 0, stall_cnt = 0.
  - stall, bubble and if_flush are 0 after reset because the scoreboard is empty.
  - Reset mid-stall drops all state; the next cycle has no stall.
- stall, bubble and if_flush are combinational from the current ID inputs and the scoreboard state.
- fwd_sel has 1-cycle latency: it is computed in ID and presented while the consumer is in EX.
- A load followed by a dependent instruction costs exactly LOAD_LAT stall cycles. ALU-to-ALU dependencies never stall.
- id_* inputs must remain stable during a stall; this block does not hold them.

## Test plan
- Defaults. Sequence: add r3,r1,r2 then sub r4,r3,r5 back-to-back. Required: stall=0; fwd_sel_rs=2 during sub's EX; fwd_sel_rt=0.
- Defaults. Sequence: lw r3 then add r4,r3,r3. Required: one stall cycle, bubble=1 on that edge, then fwd_sel_rs=fwd_sel_rt=3; stall_cnt=1.
- DEPTH=4, LOAD_LAT=2. Sequence: lw r7 then use of r7. Required: exactly 2 stall cycles, then fwd_sel=4.
- Sequence: lw r3 then dependent add, with flush asserted in the stall cycle. Required: stall=0, bubble=1, if_flush=1, sb[1] invalid, fwd_sel=0 next cycle.
- Sequence: dependent pair with hold=1 for 3 cycles mid-stall. Required: sb and stall_cnt unchanged during hold; resumes with 1 stall total. Also a write to r0 followed by a read of r0: no stall, fwd_sel=0.
- Sequence: reset asserted during a load-use stall. Required: next cycle stall=0, fwd_sel=0, stall_cnt=0.
